jam_param: RTL

Parametrised exhaustive job-assignment solver for N workers and N jobs. After a Start pulse it reads an N×N cost matrix over the W/J/Cost lookup interface and walks all N! worker-to-job assignments in lexicographic order. It reports the minimum total cost and how many assignments reach it. It replaces the fixed 8×8 solver and adds a start/busy handshake, a saturating match counter and correct running-minimum bookkeeping.

---
 rtl/jam_param_if.sv | 29 ++
 rtl/jam_param.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jam_param_if.sv
// jam_param_if: bus bundle between the assignment solver and its cost source.
// Carries the start/busy/valid handshake, the W/J cost lookup and the results.
// BestPerm only exists when BEST_PERM_EN is defined.
interface jam_param_if #(
   parameter int N   = 8,
   parameter int CW  = 7,
   parameter int MCW = 16
);
   localparam int AW = ($clog2(N) > 1) ? $clog2(N) : 1;
   localparam int SW = CW + $clog2(N);

   logic           Start;
   logic [AW-1:0]  W;
   logic [AW-1:0]  J;
   logic [CW-1:0]  Cost;
   logic [SW-1:0]  MinCost;
   logic [MCW-1:0] MatchCount;
   logic           Valid;
   logic           Busy;
`ifdef BEST_PERM_EN
   logic [N*AW-1:0] BestPerm;

   modport slave  (input Start, Cost, output W, J, MinCost, MatchCount, Valid, Busy, BestPerm);
   modport master (output Start, Cost, input W, J, MinCost, MatchCount, Valid, Busy, BestPerm);
`else
   modport slave  (input Start, Cost, output W, J, MinCost, MatchCount, Valid, Busy);
   modport master (output Start, Cost, input W, J, MinCost, MatchCount, Valid, Busy);
`endif
endinterface

// File: rtl/jam_param.sv
// jam_param: exhaustive N x N job-assignment solver.
// Loads the cost matrix row-major over W/J/Cost, then walks all N! permutations
// in lexicographic order (SUM then UPD per permutation), tracking the minimum
// total and a saturating count of permutations that reach it.
// Optional feature macro: BEST_PERM_EN adds the best-permutation register and
// the BestPerm output (lexicographically first minimal assignment).
module jam_param #(
   parameter int N   = 8,
   parameter int CW  = 7,
   parameter int MCW = 16
) (
   input logic        CLK,
   input logic        RST,
   jam_param_if.slave bus
);
   localparam int AW = ($clog2(N) > 1) ? $clog2(N) : 1;
   localparam int SW = CW + $clog2(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SUM, UPD, DONE} state_t;

   state_t         state;
   logic [CW-1:0]  mat [N][N];
   logic [AW-1:0]  p   [N];
   logic [AW-1:0]  nxt [N];
   logic           is_last;
   logic [SW-1:0]  sum_c;
   logic [SW-1:0]  sum;
   logic [SW-1:0]  min_r;
   logic [MCW-1:0] cnt;
   logic           first;
`ifdef BEST_PERM_EN
   logic [N*AW-1:0] best;
`endif

   // Cost matrix capture during LOAD; pure data, so no reset.
   always_ff @(posedge CLK) begin
      if (state == LOAD) mat[bus.W][bus.J] <= bus.Cost;
   end

   // Total cost of the current permutation; N*(2^CW-1) always fits in SW bits.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < N; i++) sum_c = sum_c + SW'(mat[i][p[i]]);
   end

   // Lexicographic next permutation (pivot k, successor l, swap, reverse tail)
   // and detection of the strictly descending last permutation.
   always_comb begin
      int k;
      int l;
      logic [AW-1:0] pk;
      logic [AW-1:0] pl;
      logic [AW-1:0] q [N];
      k       = 0;
      l       = 0;
      pk      = p[0];
      pl      = p[0];
      is_last = 1'b1;
      for (int i = 0; i < N - 1; i++) begin
         if (p[i] < p[i+1]) begin
            k       = i;
            pk      = p[i];
            is_last = 1'b0;
         end
      end
      for (int i = 1; i < N; i++) begin
         if (i > k && p[i] > pk) begin
            l  = i;
            pl = p[i];
         end
      end
      for (int i = 0; i < N; i++) q[i] = (i == k) ? pl : ((i == l) ? pk : p[i]);
      for (int i = 0; i < N; i++) begin
         nxt[i] = q[i];
         for (int j = 0; j < N; j++) begin
            if (i > k && j == N + k - i) nxt[i] = q[j];
         end
      end
   end

   // Control FSM: handshake, load addressing, running minimum and result publish.
   // DONE is entered with Busy still high; the following cycle publishes the
   // results, so Valid rises N*N + 2*N! + 1 cycles after Start is sampled.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state          <= IDLE;
         bus.W          <= '0;
         bus.J          <= '0;
         bus.MinCost    <= '0;
         bus.MatchCount <= '0;
         bus.Valid      <= 1'b0;
         bus.Busy       <= 1'b0;
         for (int i = 0; i < N; i++) p[i] <= AW'(i);
         sum            <= '0;
         min_r          <= '0;
         cnt            <= '0;
         first          <= 1'b1;
`ifdef BEST_PERM_EN
         best           <= '0;
         bus.BestPerm   <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (state == DONE && bus.Busy) begin
                  bus.MinCost    <= min_r;
                  bus.MatchCount <= cnt;
                  bus.Valid      <= 1'b1;
                  bus.Busy       <= 1'b0;
`ifdef BEST_PERM_EN
                  bus.BestPerm   <= best;
`endif
               end else if (bus.Start) begin
                  bus.Valid <= 1'b0;
                  bus.Busy  <= 1'b1;
                  bus.W     <= '0;
                  bus.J     <= '0;
                  for (int i = 0; i < N; i++) p[i] <= AW'(i);
                  first     <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (bus.J == LAST) begin
                  bus.J <= '0;
                  if (bus.W == LAST) begin
                     bus.W <= '0;
                     state <= SUM;
                  end else begin
                     bus.W <= bus.W + 1'b1;
                  end
               end else begin
                  bus.J <= bus.J + 1'b1;
               end
            end
            SUM: begin
               sum   <= sum_c;
               state <= UPD;
            end
            UPD: begin
               if (first || sum < min_r) begin
                  min_r <= sum;
                  cnt   <= MCW'(1);
                  first <= 1'b0;
`ifdef BEST_PERM_EN
                  for (int i = 0; i < N; i++) best[i*AW +: AW] <= p[i];
`endif
               end else if (sum == min_r && cnt != {MCW{1'b1}}) begin
                  cnt <= cnt + 1'b1;
               end
               if (is_last) begin
                  state <= DONE;
               end else begin
                  p     <= nxt;
                  state <= SUM;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
